if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage; the producer feeding the IF/ID pipeline register.
//  Holds the PC and reads each 32-bit instruction as 4 byte reads (little-endian)
//  over the byte-wide memory-controller port. Presents {if_pc, if_inst, if_valid}
//  to IF/ID. Honours the IF/ID stall and the branch/jump redirect from EX.
// PARAMETERS
//  ADDR_W    32  PC / memory address width
//  INST_W    32  instruction width; fixed at 4 bytes
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous reset, active-low (0 = reset)
//  rdy            in   1       global ready; 0 freezes all state
//  mem_req        out  1       byte read request to memory controller
//  mem_addr       out  ADDR_W  byte address of the current request
//  mem_ack        in   1       mem_byte valid this cycle for mem_addr
//  mem_byte       in   8       returned byte
//  branch_en      in   1       redirect request from EX, single-cycle pulse
//  branch_target  in   ADDR_W  redirect address
//  if_id_stall    in   1       IF/ID cannot accept this cycle
//  if_valid       out  1       {if_pc, if_inst} hold a complete instruction
//  if_pc          out  ADDR_W  PC of the presented instruction
//  if_inst        out  INST_W  presented instruction
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE, pc=RESET_PC, cnt=0.
//  - mem_req=0, mem_addr=0, if_valid=0, if_pc=0, if_inst=0.
//  IDLE (first cycle after reset release, rdy=1):
//  - mem_req<=1, mem_addr<=pc, go FETCH.
//  FETCH (cnt = byte index 0..3):
//  - mem_req=1, mem_addr=pc+cnt.
//  - On mem_ack: inst_buf[8*cnt+:8]<=mem_byte; cnt++; mem_addr advances next cycle.
//  - On the 4th ack: if_inst<=assembled word, if_pc<=pc, if_valid<=1, mem_req<=0,
//    cnt<=0, go HOLD.
//  - Latency: if_valid rises on the edge after the 4th ack.
//  HOLD:
//  - Outputs stable and mem_req=0 while if_id_stall=1.
//  - Transfer = if_valid & ~if_id_stall & rdy.
//  - On transfer: pc<=pc+4, if_valid<=0, mem_req<=1, mem_addr<=pc+4, go FETCH
//    (one bubble cycle between instructions).
//  Redirect (branch_en=1 & rdy=1, any state):
//  - Highest priority; beats transfer and mem_ack on the same edge.
//  - pc<=branch_target & ~3 (low 2 bits forced 0); cnt<=0; partial bytes discarded;
//    a same-cycle mem_ack byte is dropped.
//  - if_valid<=0; mem_req<=1, mem_addr<=new pc; go FETCH.
//  - A branch_en arriving on the same edge as a transfer still redirects; squashing
//    the transferred instruction is the pipeline flush's job.
//  rdy=0:
//  - No state, PC, counter or output changes.
//  - mem_ack and branch_en are ignored; the memory controller honours rdy identically.
//  Arithmetic:
//  - pc+cnt and pc+4 wrap modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0).
//  Reset mid-fetch:
//  - Immediate return to reset values; the partial word is discarded.
// TESTING
//  T1: reset, then ack bytes 13,05,10,00 at addr 0..3
//      -> if_inst=0x00100513, if_pc=0, if_valid=1 one cycle after the last ack.
//  T2: T1 with if_id_stall=1 for 3 cycles
//      -> outputs unchanged, mem_req=0; after release next mem_addr=4, if_valid=0.
//  T3: branch_en with branch_target=0x1003 after 2 of 4 bytes acked
//      -> next mem_addr=0x1000, cnt restarts; the 4 new bytes form if_inst, if_pc=0x1000.
//  T4: rdy=0 for 5 cycles mid-FETCH with mem_ack pulsed
//      -> mem_addr, cnt and outputs frozen; bytes not captured.
//  T5: rst low asynchronously between edges mid-FETCH
//      -> all outputs 0 immediately; after release fetch restarts at RESET_PC.
//  T6: pc=0xFFFFFFFC, transfer
//      -> next mem_addr=0x00000000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit instructions from four little-endian
// byte reads and presents {if_pc, if_inst, if_valid} to the IF/ID register.
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_byte,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              if_id_stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [1:0]          cnt, cnt_n;
    logic [23:0]         inst_buf, inst_buf_n;
    logic                mem_req_n, if_valid_n;
    logic [ADDR_W-1:0]   mem_addr_n, if_pc_n;
    logic [INST_W-1:0]   if_inst_n;
    logic [ADDR_W-1:0]   redirect_pc;

    // Handshake: an instruction moves to IF/ID on any rdy edge where if_valid=1
    // and if_id_stall=0; a byte is taken on any rdy edge where mem_req=1 and mem_ack=1.
    assign redirect_pc = branch_target & ~ADDR_W'(3);
    assign fsm_state   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            cnt      <= 2'd0;
            inst_buf <= 24'd0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            cnt      <= cnt_n;
            inst_buf <= inst_buf_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            if_valid <= if_valid_n;
            if_pc    <= if_pc_n;
            if_inst  <= if_inst_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        cnt_n      = cnt;
        inst_buf_n = inst_buf;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        if_valid_n = if_valid;
        if_pc_n    = if_pc;
        if_inst_n  = if_inst;

        if (rdy) begin
            if (branch_en) begin
                // Redirect wins over byte capture and transfer on the same edge.
                pc_n       = redirect_pc;
                cnt_n      = 2'd0;
                if_valid_n = 1'b0;
                mem_req_n  = 1'b1;
                mem_addr_n = redirect_pc;
                state_n    = FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                        state_n    = FETCH;
                    end
                    FETCH: begin
                        if (mem_ack) begin
                            case (cnt)
                                2'd0: inst_buf_n[7:0]   = mem_byte;
                                2'd1: inst_buf_n[15:8]  = mem_byte;
                                2'd2: inst_buf_n[23:16] = mem_byte;
                                default: ;
                            endcase
                            if (cnt == 2'd3) begin
                                if_inst_n  = {mem_byte, inst_buf};
                                if_pc_n    = pc;
                                if_valid_n = 1'b1;
                                mem_req_n  = 1'b0;
                                cnt_n      = 2'd0;
                                state_n    = HOLD;
                            end else begin
                                cnt_n      = cnt + 2'd1;
                                mem_addr_n = pc + ADDR_W'(cnt) + ADDR_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (if_valid && !if_id_stall) begin
                            pc_n       = pc + ADDR_W'(4);
                            if_valid_n = 1'b0;
                            mem_req_n  = 1'b1;
                            mem_addr_n = pc + ADDR_W'(4);
                            state_n    = FETCH;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed vector bench for if_fetch: each record is driven on a falling edge and
// the registered outputs are compared on the following falling edge.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_byte;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        if_id_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  fsm_state;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_byte(mem_byte),
        .branch_en(branch_en), .branch_target(branch_target), .if_id_stall(if_id_stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .fsm_state(fsm_state)
    );

    typedef struct {
        string       name;
        logic        rdy;
        logic        ack;
        logic [7:0]  bval;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic a, logic [7:0] b, logic br,
                                logic [31:0] t, logic s, logic e_req, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_pc, logic [31:0] e_inst);
        vec_t v;
        v.name = name; v.rdy = r; v.ack = a; v.bval = b; v.br = br; v.tgt = t; v.stall = s;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic check_outputs(string name, logic e_req, logic [31:0] e_addr,
                                 logic e_valid, logic [31:0] e_pc, logic [31:0] e_inst);
        n_vec++;
        if (mem_req !== e_req) begin
            n_fail++; $display("FAIL %s mem_req: got %0b want %0b", name, mem_req, e_req);
        end
        if (mem_addr !== e_addr) begin
            n_fail++; $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, e_addr);
        end
        if (if_valid !== e_valid) begin
            n_fail++; $display("FAIL %s if_valid: got %0b want %0b", name, if_valid, e_valid);
        end
        if (if_pc !== e_pc) begin
            n_fail++; $display("FAIL %s if_pc: got %h want %h", name, if_pc, e_pc);
        end
        if (if_inst !== e_inst) begin
            n_fail++; $display("FAIL %s if_inst: got %h want %h", name, if_inst, e_inst);
        end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; mem_ack = 1'b0; mem_byte = 8'h00;
        branch_en = 1'b0; branch_target = 32'h0; if_id_stall = 1'b0;
    endtask

    // Called on a falling edge; returns on the next falling edge after checking.
    task automatic apply_vec(vec_t v);
        rdy = v.rdy; mem_ack = v.ack; mem_byte = v.bval;
        branch_en = v.br; branch_target = v.tgt; if_id_stall = v.stall;
        @(posedge clk);
        @(negedge clk);
        check_outputs(v.name, v.e_req, v.e_addr, v.e_valid, v.e_pc, v.e_inst);
    endtask

    initial begin
        // T1: first instruction, 4 acks
        vecs.push_back(mk("t1_idle",   1,0,8'h00,0,0,0, 1,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk("t1_b0",     1,1,8'h13,0,0,0, 1,32'h1,0,32'h0,32'h0));
        vecs.push_back(mk("t1_b1",     1,1,8'h05,0,0,0, 1,32'h2,0,32'h0,32'h0));
        vecs.push_back(mk("t1_b2",     1,1,8'h10,0,0,0, 1,32'h3,0,32'h0,32'h0));
        vecs.push_back(mk("t1_b3",     1,1,8'h00,0,0,1, 0,32'h3,1,32'h0,32'h00100513));
        // T2: stall holds, then transfer with bubble
        vecs.push_back(mk("t2_stall0", 1,0,8'h00,0,0,1, 0,32'h3,1,32'h0,32'h00100513));
        vecs.push_back(mk("t2_stall1", 1,1,8'hff,0,0,1, 0,32'h3,1,32'h0,32'h00100513));
        vecs.push_back(mk("t2_stall2", 1,0,8'h00,0,0,1, 0,32'h3,1,32'h0,32'h00100513));
        vecs.push_back(mk("t2_xfer",   1,0,8'h00,0,0,0, 1,32'h4,0,32'h0,32'h00100513));
        // T3: redirect after 2 bytes; same-cycle ack byte dropped
        vecs.push_back(mk("t3_b0",     1,1,8'haa,0,0,0, 1,32'h5,0,32'h0,32'h00100513));
        vecs.push_back(mk("t3_b1",     1,1,8'hbb,0,0,0, 1,32'h6,0,32'h0,32'h00100513));
        vecs.push_back(mk("t3_branch", 1,1,8'hcc,1,32'h1003,0, 1,32'h1000,0,32'h0,32'h00100513));
        vecs.push_back(mk("t3_n0",     1,1,8'h93,0,0,0, 1,32'h1001,0,32'h0,32'h00100513));
        // T4: rdy=0 for 5 cycles; acks and a branch are ignored
        vecs.push_back(mk("t4_frz0",   0,1,8'h55,0,0,0, 1,32'h1001,0,32'h0,32'h00100513));
        vecs.push_back(mk("t4_frz1",   0,1,8'h66,0,0,0, 1,32'h1001,0,32'h0,32'h00100513));
        vecs.push_back(mk("t4_frz2",   0,1,8'h77,1,32'h2000,0, 1,32'h1001,0,32'h0,32'h00100513));
        vecs.push_back(mk("t4_frz3",   0,1,8'h88,0,0,1, 1,32'h1001,0,32'h0,32'h00100513));
        vecs.push_back(mk("t4_frz4",   0,1,8'h99,0,0,0, 1,32'h1001,0,32'h0,32'h00100513));
        vecs.push_back(mk("t3_n1",     1,1,8'h05,0,0,0, 1,32'h1002,0,32'h0,32'h00100513));
        vecs.push_back(mk("t3_n2",     1,1,8'h10,0,0,0, 1,32'h1003,0,32'h0,32'h00100513));
        vecs.push_back(mk("t3_n3",     1,1,8'h00,0,0,1, 0,32'h1003,1,32'h1000,32'h00100593));
        // Redirect beats transfer; T6 wrap of pc+4
        vecs.push_back(mk("br_vs_xfer",1,0,8'h00,1,32'hffffffff,0, 1,32'hfffffffc,0,32'h1000,32'h00100593));
        vecs.push_back(mk("t6_b0",     1,1,8'h01,0,0,0, 1,32'hfffffffd,0,32'h1000,32'h00100593));
        vecs.push_back(mk("t6_b1",     1,1,8'h02,0,0,0, 1,32'hfffffffe,0,32'h1000,32'h00100593));
        vecs.push_back(mk("t6_b2",     1,1,8'h03,0,0,0, 1,32'hffffffff,0,32'h1000,32'h00100593));
        vecs.push_back(mk("t6_b3",     1,1,8'h04,0,0,0, 0,32'hffffffff,1,32'hfffffffc,32'h04030201));
        vecs.push_back(mk("t6_wrap",   1,0,8'h00,0,0,0, 1,32'h0,0,32'hfffffffc,32'h04030201));
        vecs.push_back(mk("t6_byte",   1,1,8'h77,0,0,0, 1,32'h1,0,32'hfffffffc,32'h04030201));

        // Reset state, including across a clock edge while held in reset
        idle_inputs();
        rst = 1'b0;
        #1 check_outputs("reset_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("reset_held", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // T5: async reset between edges mid-FETCH (one byte of a word captured)
        idle_inputs();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_outputs("t5_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        apply_vec(mk("t5_idle", 1,0,8'h00,0,0,0, 1,32'h0,0,32'h0,32'h0));
        apply_vec(mk("t5_b0",   1,1,8'h11,0,0,0, 1,32'h1,0,32'h0,32'h0));
        apply_vec(mk("t5_b1",   1,1,8'h22,0,0,0, 1,32'h2,0,32'h0,32'h0));
        apply_vec(mk("t5_b2",   1,1,8'h33,0,0,0, 1,32'h3,0,32'h0,32'h0));
        apply_vec(mk("t5_b3",   1,1,8'h44,0,0,1, 0,32'h3,1,32'h0,32'h44332211));
        apply_vec(mk("t5_xfer", 1,0,8'h00,0,0,0, 1,32'h4,0,32'h0,32'h44332211));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
